minimal_onchip_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 1024x32 on-chip RAM (`minimal_onchip_memory2_0`) between two Avalon-MM masters, e.g. the Nios II data master (port 0) and a DMA/streaming engine (port 1). It presents two Avalon-MM slave ports with waitrequest/readdatavalid and drives the RAM's s1 slave interface: address, byteenable, chipselect, write, writedata, clken and readdata. It sits in the Qsys system between the interconnect and the RAM instance.

---
 rtl/minimal_onchip_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_minimal_onchip_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimal_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : minimal_onchip_mem_arbiter
// Purpose  : Two-port Avalon-MM arbiter in front of the single-port on-chip
//            RAM. Round-robin tie-break from IDLE, and direct handoff between
//            ports while BUSY, so contention gives one access per cycle.
// Options  : MEM_ARB_FIXED_PRIO_EN -- when defined, an IDLE tie always goes
//            to port 0 (no last-grant history is kept).
// Revision : 1.0 - initial release
// ============================================================================
module minimal_onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  // Requester port 0
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  // Requester port 1
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  // RAM s1 interface
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] r_state;
  logic       r_grant;      // port currently driving the RAM while BUSY
  logic       r_rdv;        // a read was accepted last cycle
  logic       r_rdv_port;   // which port that read belongs to

  logic       w_req0;
  logic       w_req1;
  logic       w_busy;
  logic       w_pick;       // winner when leaving IDLE
  logic       w_sel1;       // RAM side muxes select port 1
  logic       w_g_read;
  logic       w_g_write;
  logic       w_other_req;

  assign w_req0      = s0_read | s0_write;
  assign w_req1      = s1_read | s1_write;
  assign w_busy      = (r_state == ST_BUSY);
  assign w_g_read    = r_grant ? s1_read  : s0_read;
  assign w_g_write   = r_grant ? s1_write : s0_write;
  assign w_other_req = r_grant ? w_req0   : w_req1;
  // In IDLE the address/data lanes simply follow port 0; chipselect is low.
  assign w_sel1      = w_busy & r_grant;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it asks; port 1 only when alone.
  assign w_pick = ~w_req0;
`else
  logic r_last_grant;

  // Tie goes to the port not served most recently.
  assign w_pick = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

  // Remember the port served in every BUSY cycle (reset favours port 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_busy) begin
      r_last_grant <= r_grant;
    end
  end
`endif

  // Arbitration FSM: IDLE grants, BUSY hands off to the other port or idles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!reset_req && (w_req0 || w_req1)) begin
        r_state <= ST_BUSY;
        r_grant <= w_pick;
      end
    end else begin
      // Same-port back-to-back always passes through IDLE, so only the
      // other port may keep the FSM in BUSY.
      if (w_other_req && !reset_req) begin
        r_grant <= ~r_grant;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Read-return tracking: RAM data is valid one cycle after the access.
  // A write with read also set is a write only, so it returns nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdv      <= 1'b0;
      r_rdv_port <= 1'b0;
    end else begin
      r_rdv <= w_busy & w_g_read & ~w_g_write;
      if (w_busy) begin
        r_rdv_port <= r_grant;
      end
    end
  end

  // RAM side
  assign m_address    = w_sel1 ? s1_address    : s0_address;
  assign m_byteenable = w_sel1 ? s1_byteenable : s0_byteenable;
  assign m_writedata  = w_sel1 ? s1_writedata  : s0_writedata;
  assign m_chipselect = w_busy;
  // A dropped request leaves write low, so that cycle is a harmless read.
  assign m_write      = w_busy & w_g_write;
  assign m_clken      = ~reset_req;

  // Requester side
  assign s0_waitrequest   = ~(w_busy & ~r_grant);
  assign s1_waitrequest   = ~(w_busy &  r_grant);
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = r_rdv & ~r_rdv_port;
  assign s1_readdatavalid = r_rdv &  r_rdv_port;

endmodule
`default_nettype wire

// File: tb/tb_minimal_onchip_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_minimal_onchip_mem_arbiter
// Purpose  : Directed bench with a behavioural arbiter/memory model, a RAM
//            device model, and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minimal_onchip_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reset_req = 1'b0;
  logic [AW-1:0] s0_address = '0, s1_address = '0;
  logic [BW-1:0] s0_byteenable = '0, s1_byteenable = '0;
  logic          s0_read = 1'b0, s1_read = 1'b0, s0_write = 1'b0, s1_write = 1'b0;
  logic [DW-1:0] s0_writedata = '0, s1_writedata = '0;
  logic          s0_waitrequest, s1_waitrequest;
  logic [DW-1:0] s0_readdata, s1_readdata;
  logic          s0_readdatavalid, s1_readdatavalid;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_byteenable;
  logic          m_chipselect, m_write, m_clken;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata = '0;

  always #5 clk = ~clk;

  minimal_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // ---------------- RAM device model (registered q, old-data on write) ----
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] mmem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
  end

  logic          r_cs, r_we, r_ce;
  logic [AW-1:0] r_a;
  logic [BW-1:0] r_be;
  logic [DW-1:0] r_wd;
  // Latch the RAM pins mid-cycle, apply them at the rising edge.
  always @(negedge clk) begin
    r_cs = m_chipselect; r_we = m_write; r_ce = m_clken;
    r_a = m_address; r_be = m_byteenable; r_wd = m_writedata;
  end
  always @(posedge clk) begin
    if (r_ce && r_cs) begin
      m_readdata <= ram[r_a];
      if (r_we)
        for (int b = 0; b < BW; b++)
          if (r_be[b]) ram[r_a][8*b +: 8] = r_wd[8*b +: 8];
    end
  end

  // ---------------- behavioural model ------------------------------------
  function automatic logic f_rd(int p); return (p == 0) ? s0_read : s1_read; endfunction
  function automatic logic f_wr(int p); return (p == 0) ? s0_write : s1_write; endfunction
  function automatic logic f_rq(int p); return f_rd(p) | f_wr(p); endfunction
  function automatic logic [AW-1:0] f_ad(int p); return (p == 0) ? s0_address : s1_address; endfunction
  function automatic logic [DW-1:0] f_wd(int p); return (p == 0) ? s0_writedata : s1_writedata; endfunction
  function automatic logic [BW-1:0] f_be(int p); return (p == 0) ? s0_byteenable : s1_byteenable; endfunction

  int mc = -1;          // port being served this cycle, -1 when nobody
  int ml = 1;           // port served most recently
  int mp = -1;          // port owed read data this cycle, -1 when none
  int np;
  logic [DW-1:0] mpd = '0;
  bit  mpchk = 1'b0;    // data is only predictable if the RAM was clocked

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mc = -1; ml = 1; mp = -1;
    end else begin
      np = -1;
      if (mc >= 0) begin
        if (f_wr(mc)) begin
          if (!reset_req)
            for (int b = 0; b < BW; b++)
              if (f_be(mc)[b]) mmem[f_ad(mc)][8*b +: 8] = f_wd(mc)[8*b +: 8];
        end else if (f_rd(mc)) begin
          np = mc; mpd = mmem[f_ad(mc)]; mpchk = !reset_req;
        end
        ml = mc;
        mc = (f_rq(1 - mc) && !reset_req) ? 1 - mc : -1;
      end else if (!reset_req && (f_rq(0) || f_rq(1))) begin
        mc = (f_rq(0) && f_rq(1)) ? 1 - ml : (f_rq(1) ? 1 : 0);
      end
      mp = np;
    end
  end

  int rdv_port[$], rdv_cyc[$];
  logic [DW-1:0] rdv_data[$];
  int cyc = 0;

  // ---------------- compare process --------------------------------------
  always @(negedge clk) begin
    chk("s0_waitrequest", 32'(s0_waitrequest), 32'(mc != 0));
    chk("s1_waitrequest", 32'(s1_waitrequest), 32'(mc != 1));
    chk("m_chipselect", 32'(m_chipselect), 32'(mc >= 0));
    chk("m_write", 32'(m_write), 32'((mc >= 0) && f_wr(mc)));
    chk("m_clken", 32'(m_clken), 32'(!reset_req));
    chk("s0_readdatavalid", 32'(s0_readdatavalid), 32'(mp == 0));
    chk("s1_readdatavalid", 32'(s1_readdatavalid), 32'(mp == 1));
    if (mc >= 0) begin
      chk("m_address", 32'(m_address), 32'(f_ad(mc)));
      if (f_wr(mc)) begin
        chk("m_writedata", m_writedata, f_wd(mc));
        chk("m_byteenable", 32'(m_byteenable), 32'(f_be(mc)));
      end
    end
    if (mp >= 0 && mpchk)
      chk("readdata", (mp == 0) ? s0_readdata : s1_readdata, mpd);
    if (s0_readdatavalid) begin rdv_port.push_back(0); rdv_cyc.push_back(cyc); rdv_data.push_back(s0_readdata); end
    if (s1_readdatavalid) begin rdv_port.push_back(1); rdv_cyc.push_back(cyc); rdv_data.push_back(s1_readdata); end
  end

  // ---------------- masters ----------------------------------------------
  typedef struct { bit rd; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be; } op_t;
  op_t q0[$], q1[$];
  int  pres0 = 0, pres1 = 0;
  int  acc_port[$], acc_cyc[$], acc_pres[$];

  task automatic drive();
    if (q0.size() != 0) begin
      s0_read = q0[0].rd; s0_write = q0[0].wr; s0_address = q0[0].a;
      s0_writedata = q0[0].d; s0_byteenable = q0[0].be;
    end else begin
      s0_read = 1'b0; s0_write = 1'b0;
    end
    if (q1.size() != 0) begin
      s1_read = q1[0].rd; s1_write = q1[0].wr; s1_address = q1[0].a;
      s1_writedata = q1[0].d; s1_byteenable = q1[0].be;
    end else begin
      s1_read = 1'b0; s1_write = 1'b0;
    end
  endtask

  task automatic push(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o;
    o.rd = rd; o.wr = wr; o.a = a; o.d = d; o.be = be;
    if (p == 0) begin
      if (q0.size() == 0) pres0 = cyc;
      q0.push_back(o);
    end else begin
      if (q1.size() == 0) pres1 = cyc;
      q1.push_back(o);
    end
    drive();
  endtask

  task automatic cycle();
    bit a0, a1;
    @(negedge clk);
    a0 = (q0.size() != 0) && !s0_waitrequest;
    a1 = (q1.size() != 0) && !s1_waitrequest;
    @(posedge clk);
    #1;
    if (a0) begin acc_port.push_back(0); acc_cyc.push_back(cyc); acc_pres.push_back(pres0); void'(q0.pop_front()); end
    if (a1) begin acc_port.push_back(1); acc_cyc.push_back(cyc); acc_pres.push_back(pres1); void'(q1.pop_front()); end
    cyc++;
    if (a0) pres0 = cyc;
    if (a1) pres1 = cyc;
    drive();
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q0.size() + q1.size());
    end
    repeat (extra) cycle();
  endtask

  task automatic clear_logs();
    acc_port.delete(); acc_cyc.delete(); acc_pres.delete();
    rdv_port.delete(); rdv_cyc.delete(); rdv_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int n_acc;

  initial begin
    repeat (2) cycle();
    chk("reset_s0_waitrequest", 32'(s0_waitrequest), 32'd1);
    chk("reset_m_chipselect", 32'(m_chipselect), 32'd0);
    reset = 1'b0;
    cycle();

    // Single write then read-back on port 0
    clear_logs();
    push(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    drain(2);
    chk("wr_accept_count", acc_port.size(), 1);
    if (acc_port.size() >= 1) chk("wr_accept_latency", acc_cyc[0] - acc_pres[0], 1);
    clear_logs();
    push(0, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    drain(2);
    chk("rd_rdv_count", rdv_port.size(), 1);
    if (rdv_port.size() >= 1 && acc_pres.size() >= 1) begin
      chk("rd_data", rdv_data[0], 32'hDEADBEEF);
      chk("rd_rdv_latency", rdv_cyc[0] - acc_pres[0], 2);
    end

    // Seed data, s1 served last
    push(0, 1'b0, 1'b1, 10'h010, 32'h10000001, 4'hF);
    drain(1);
    push(1, 1'b0, 1'b1, 10'h021, 32'h20000002, 4'hF);
    drain(1);

    // Two-port read contention
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 1'b0, AW'(10'h010 + i), 32'h0, 4'h0);
      push(1, 1'b1, 1'b0, AW'(10'h020 + i), 32'h0, 4'h0);
    end
    drain(2);
    chk("cont_accept_count", acc_port.size(), 8);
    chk("cont_rdv_count", rdv_port.size(), 8);
    if (acc_port.size() == 8 && rdv_port.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("cont_accept_port", acc_port[i], i % 2);
        chk("cont_accept_cycle", acc_cyc[i] - acc_cyc[0], i);
        chk("cont_rdv_port", rdv_port[i], i % 2);
        chk("cont_rdv_cycle", rdv_cyc[i] - acc_cyc[i], 1);
      end
      chk("cont_data0", rdv_data[0], 32'h10000001);
      chk("cont_data3", rdv_data[3], 32'h20000002);
    end

    // Round robin: s1 last -> s0 wins; s0 last -> s1 wins
    push(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    drain(1);
    clear_logs();
    push(0, 1'b1, 1'b0, 10'h011, 32'h0, 4'h0);
    push(1, 1'b1, 1'b0, 10'h022, 32'h0, 4'h0);
    drain(1);
    if (acc_port.size() >= 1) chk("rr_after_s1", acc_port[0], 0);
    push(0, 1'b1, 1'b0, 10'h012, 32'h0, 4'h0);
    drain(1);
    clear_logs();
    push(0, 1'b1, 1'b0, 10'h013, 32'h0, 4'h0);
    push(1, 1'b1, 1'b0, 10'h023, 32'h0, 4'h0);
    drain(1);
    if (acc_port.size() >= 1) chk("rr_after_s0", acc_port[0], 1);

    // Read and write both set: write only, no read return
    clear_logs();
    push(0, 1'b1, 1'b1, 10'h040, 32'hA5A5A5A5, 4'hF);
    drain(3);
    chk("rw_no_rdv", rdv_port.size(), 0);
    push(0, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
    drain(2);
    if (rdv_data.size() >= 1) chk("rw_data", rdv_data[0], 32'hA5A5A5A5);

    // Byte lanes on port 1
    clear_logs();
    push(1, 1'b0, 1'b1, 10'h030, 32'hFFFFFFFF, 4'hF);
    push(1, 1'b0, 1'b1, 10'h030, 32'h11223344, 4'h5);
    push(1, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
    drain(2);
    chk("be_rdv_count", rdv_port.size(), 1);
    if (rdv_data.size() >= 1) chk("be_data", rdv_data[0], 32'hFF22FF44);

    // reset_req while both ports stream
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b1, 1'b0, AW'(10'h010 + i), 32'h0, 4'h0);
      push(1, 1'b1, 1'b0, AW'(10'h020 + i), 32'h0, 4'h0);
    end
    repeat (3) cycle();
    n_acc = acc_port.size();
    chk("rr_pre_accepts", n_acc, 2);
    reset_req = 1'b1;
    repeat (6) cycle();
    chk("rr_held_accepts", acc_port.size(), n_acc + 1);
    chk("rr_clken", 32'(m_clken), 32'd0);
    reset_req = 1'b0;
    drain(2);
    chk("rr_resume_accepts", acc_port.size(), 12);

    // Reset asserted mid-BUSY with a read return pending
    clear_logs();
    push(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    push(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    push(0, 1'b1, 1'b0, 10'h011, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("pre_reset_rdv", 32'(s0_readdatavalid), 32'd1);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    @(negedge clk);
    chk("mid_reset_s0_waitrequest", 32'(s0_waitrequest), 32'd1);
    chk("mid_reset_s1_waitrequest", 32'(s1_waitrequest), 32'd1);
    chk("mid_reset_s0_rdv", 32'(s0_readdatavalid), 32'd0);
    chk("mid_reset_s1_rdv", 32'(s1_readdatavalid), 32'd0);
    chk("mid_reset_m_chipselect", 32'(m_chipselect), 32'd0);
    cycle();
    reset = 1'b0;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
